// File: rtl/md_unit_pkg.sv
// Shared MD-unit constants: md_op encodings, default latencies and FSM state type.
// The stall controller imports this package so both sides decode the same codes.
package md_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

    // Operations that occupy the unit for more than zero cycles.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath: 64-bit signed/unsigned multiply, 32-bit signed/unsigned divide,
// and a divide-by-zero flag. Divide results are {remainder, quotient} on {o_hi, o_lo}.
module md_core
    import md_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_by_zero
);

    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_dz;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    always_comb begin
        w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
        w_neg_a  = w_signed & i_a[31];
        w_neg_b  = w_signed & i_b[31];

        // Low 64 bits of the sign-extended product are the exact signed result.
        w_ext_a = {{32{w_neg_a}}, i_a};
        w_ext_b = {{32{w_neg_b}}, i_b};
        w_prod  = w_ext_a * w_ext_b;

        // Divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        w_mag_a   = w_neg_a ? (~i_a + 32'd1) : i_a;
        w_mag_b   = w_neg_b ? (~i_b + 32'd1) : i_b;
        w_dz      = (i_b == 32'd0);
        w_divisor = w_dz ? 32'd1 : w_mag_b;
        w_uq      = w_mag_a / w_divisor;
        w_ur      = w_mag_a % w_divisor;
        w_q       = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
        w_r       = w_neg_a ? (~w_ur + 32'd1) : w_ur;

        if (md_is_div(i_op)) begin
            o_hi = w_r;
            o_lo = w_q;
        end else begin
            o_hi = w_prod[63:32];
            o_lo = w_prod[31:0];
        end
        o_div_by_zero = md_is_div(i_op) & w_dz;
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional `MDU_ABORT_EN adds an abort
// input that cancels an in-flight operation (or a same-cycle start) without commit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_sel,
`ifdef MDU_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e       r_state, w_state;
    logic [CntW-1:0] r_cnt, w_cnt;
    logic [31:0]     r_pend_hi, w_pend_hi;
    logic [31:0]     r_pend_lo, w_pend_lo;
    logic            r_pend_dz, w_pend_dz;
    logic [31:0]     r_hi, w_hi;
    logic [31:0]     r_lo, w_lo;

    logic [31:0]     w_core_hi;
    logic [31:0]     w_core_lo;
    logic            w_core_dz;
    logic            w_abort;

`ifdef MDU_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    md_core u_core (
        .i_op          (md_op),
        .i_a           (src_a),
        .i_b           (src_b),
        .o_hi          (w_core_hi),
        .o_lo          (w_core_lo),
        .o_div_by_zero (w_core_dz)
    );

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_pend_hi = r_pend_hi;
        w_pend_lo = r_pend_lo;
        w_pend_dz = r_pend_dz;
        w_hi      = r_hi;
        w_lo      = r_lo;

        case (r_state)
            StIdle: begin
                if (start && !w_abort) begin
                    if (md_is_arith(md_op)) begin
                        w_pend_hi = w_core_hi;
                        w_pend_lo = w_core_lo;
                        w_pend_dz = w_core_dz;
                        w_cnt     = md_is_div(md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        w_state   = StRun;
                    end else if (md_op == MD_MTHI) begin
                        w_hi = src_a;
                    end else if (md_op == MD_MTLO) begin
                        w_lo = src_a;
                    end
                end
            end
            StRun: begin
                // Any start here is ignored; the stall controller keeps it from happening.
                if (w_abort) begin
                    w_state = StIdle;
                    w_cnt   = '0;
                end else if (r_cnt == CntW'(1)) begin
                    if (!r_pend_dz) begin
                        w_hi = r_pend_hi;
                        w_lo = r_pend_lo;
                    end
                    w_state = StIdle;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt - CntW'(1);
                end
            end
            default: begin
                w_state = StIdle;
                w_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_pend_hi <= w_pend_hi;
            r_pend_lo <= w_pend_lo;
            r_pend_dz <= w_pend_dz;
            r_hi      <= w_hi;
            r_lo      <= w_lo;
        end
    end

    assign busy      = (r_state == StRun);
    assign stall_req = (start & md_is_arith(md_op)) | busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign md_out    = rd_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written multi-cycle
// sequences, and random operations checked against an arithmetic reference model.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        abort;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .rd_sel    (rd_sel),
`ifdef MDU_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .md_out    (md_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ebusy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp, sq, sr;
        longint unsigned up;
        case (op)
            MD_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MD_MULTU: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            MD_DIV: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            MD_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_busy(input logic [2:0] op);
        if (op == MD_MULT || op == MD_MULTU) return MC;
        if (op == MD_DIV || op == MD_DIVU) return DC;
        return 0;
    endfunction

    // Entered and left at a falling edge; start is sampled at the next rising edge.
    // Returns after the first sample with busy low (cycle t+N+1).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int nstall);
        nbusy  = 0;
        nstall = 0;
        md_op  = op;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        #1;
        if (stall_req) nstall++;
        if (busy) nbusy++;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (stall_req) nstall++;
            if (busy) nbusy++;
            if (!busy) break;
        end
    endtask

    task automatic check_state(input string nm, input int nbusy, input int ebusy);
        chk({nm, "_busy_cycles"}, 32'(nbusy), 32'(ebusy));
        chk({nm, "_hi"}, hi, m_hi);
        chk({nm, "_lo"}, lo, m_lo);
    endtask

    // Start during busy is never legal stimulus; flag it if the bench ever produces it.
    always @(posedge clk) begin
        if (reset_n === 1'b1 && start === 1'b1 && busy === 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: got start=1 busy=1 expected no overlap");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, ns, nb2, ns2;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3]  = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
        vecs[4]  = '{MD_MTHI,  32'h000000AA, 32'hDEADBEEF, 32'h000000AA, 32'h00000003, 0};
        vecs[5]  = '{MD_MTLO,  32'h000000BB, 32'h0,        32'h000000AA, 32'h000000BB, 0};
        vecs[6]  = '{MD_DIV,   32'd5,        32'd0,        32'h000000AA, 32'h000000BB, DC};
        vecs[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[8]  = '{MD_DIVU,  32'h12345678, 32'd0,        32'h00000000, 32'h80000000, DC};
        vecs[9]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vecs[10] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[11] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};

        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = MD_MULT;
        src_a   = '0;
        src_b   = '0;
        rd_sel  = 1'b0;
        abort   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        m_hi = '0;
        m_lo = '0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // mthi: visible next cycle, no busy, no stall.
        run_op(MD_MTHI, 32'h12345678, 32'd0, nb, ns);
        m_hi = 32'h12345678;
        check_state("mthi", nb, 0);
        chk("mthi_stall_cycles", 32'(ns), 32'd0);
        rd_sel = 1'b0;
        #1 chk("mthi_md_out_hi", md_out, 32'h12345678);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, ns);
            m_hi = vecs[i].ehi;
            m_lo = vecs[i].elo;
            check_state($sformatf("vec%0d", i), nb, vecs[i].ebusy);
            chk($sformatf("vec%0d_stall_cycles", i), 32'(ns),
                32'(vecs[i].ebusy == 0 ? 0 : vecs[i].ebusy + 1));
            rd_sel = 1'b1;
            #1 chk($sformatf("vec%0d_md_out_lo", i), md_out, vecs[i].elo);
            rd_sel = 1'b0;
            #1 chk($sformatf("vec%0d_md_out_hi", i), md_out, vecs[i].ehi);
            @(negedge clk);
        end

        // Reset on busy cycle 3 of a multiply: everything clears, no late commit.
        md_op = MD_MULT;
        src_a = 32'd3;
        src_b = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_hi", hi, 32'd0);
        chk("abort_rst_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check_state("abort_rst_late", 0, 0);
        chk("abort_rst_late_busy", 32'(busy), 32'd0);

        // Back-to-back: divu starts in the cycle right after mult commits.
        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, nb, ns);
        m_hi = 32'hFFFFFFFF;
        m_lo = 32'hFFFFFFFA;
        check_state("b2b_mult", nb, MC);
        run_op(MD_DIVU, 32'd100, 32'd7, nb2, ns2);
        m_hi = 32'd2;
        m_lo = 32'd14;
        check_state("b2b_divu", nb2, DC);
        chk("b2b_stall_total", 32'(ns + ns2), 32'(MC + 1 + DC + 1));
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb);
            run_op(rop, ra, rb, nb, ns);
            check_state($sformatf("rand%0d_op%0d", i, rop), nb, exp_busy(rop));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
